// File: rtl/data_mem_pkg.sv
// Shared encodings for the MEM-stage data memory: access sizes, FSM states
// and the byte-enable helper.
package data_mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_B:  byte_en = 4'b0001 << lane;
            SIZE_H:  byte_en = 4'b0011 << lane;
            SIZE_W:  byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_lsu_load_align.sv
// Lane select plus sign/zero extension of a 32-bit memory word; shared with
// the cache fill path.
module mem_load_align
    import data_mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = lane[1] ? word[31:16] : word[15:0];

        result = '0;
        case (size)
            SIZE_B:  result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            SIZE_H:  result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            SIZE_W:  result = word;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable RV32 data memory with sized loads/stores, a valid/ready
// request port, a registered one-cycle response and an optional clear sweep.
module data_mem_lsu
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS    = 256,
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int AW            = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    logic [3:0][7:0] mem [DEPTH_WORDS];

    state_e        state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic          fire, acc_err, misalign, out_of_range;
    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic [3:0]    be;
    logic [31:0]   wdata_rep, rd_word, ld_data;

    // Ready is forced low while reset is held so nothing fires under reset.
    assign req_ready    = req_ready_q & resetn;
    assign fire         = req_valid & req_ready;
    assign idx          = req_addr[AW+1:2];
    assign lane         = req_addr[1:0];
    assign out_of_range = |req_addr[31:AW+2];
    assign misalign     = ((req_size == SIZE_H) && req_addr[0]) ||
                          ((req_size == SIZE_W) && (req_addr[1:0] != 2'b00));
    assign acc_err      = (req_size == 2'b11) || misalign || out_of_range;
    assign be           = byte_en(req_size, lane);
    assign rd_word      = mem[idx];

    always_comb begin
        case (req_size)
            SIZE_B:  wdata_rep = {4{req_wdata[7:0]}};
            SIZE_H:  wdata_rep = {2{req_wdata[15:0]}};
            default: wdata_rep = req_wdata;
        endcase
    end

    mem_load_align u_align (
        .word        (rd_word),
        .lane        (lane),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .result      (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        clr_idx_d    = clr_idx_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = fire;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d     = ST_READY;
                    req_ready_d = 1'b1;
                    clr_idx_d   = '0;
                end
            end
            default: req_ready_d = 1'b1;
        endcase
        if (fire) begin
            resp_err_d   = acc_err;
            resp_rdata_d = (acc_err || req_we) ? 32'h0 : ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_idx_q    <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Storage has no reset; only the sweep or an accepted store changes it.
    always_ff @(posedge clk) begin
        if (resetn && (state_q == ST_CLEAR)) begin
            mem[clr_idx_q] <= '0;
        end else if (fire && req_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][b] <= wdata_rep[8*b +: 8];
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
